lsu_ctrl: RTL and testbench

Multi-cycle load/store sequencer between the single-cycle core's decode/ALU stage and a data memory with a request/grant/response handshake. It accepts one load or store, selected by RV32I funct3, from the core. It drives aligned word accesses with byte enables, then sign- or zero-extends load data. It stalls the core until the access completes, errors, or times out.

---
 rtl/lsu_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl
//
// Multi-cycle load/store sequencer between the core's decode/ALU stage and a
// data memory with a request/grant/response handshake. One RV32I load or
// store is accepted at a time. The access is turned into an aligned word
// request with byte enables and lane-replicated store data. Load data is
// sign- or zero-extended. The core is stalled until the access completes,
// is rejected as illegal, or times out.
//
// Ports
//   clk_i, rst_ni      clock, synchronous active-low reset
//   valid_i            core presents a load/store (held stable while stalled)
//   is_store_i         1 = store, 0 = load
//   funct3_i           [1:0] size (byte/half/word), [2] unsigned load
//   addr_i, wdata_i    byte address and store data from the core
//   stall_o            freeze PC / register file write
//   done_o, err_o      one-cycle completion pulse, qualified by error
//   rdata_o            extended load result, valid with done_o
//   mem_req_o ...      memory request side (addr, we, be, wdata)
//   mem_gnt_i          request accepted this cycle
//   mem_rvalid_i       read data valid (only honoured while waiting)
//   mem_rdata_i        read word
// ---------------------------------------------------------------------------
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned CntW = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_e;

    state_e          state_q;
    logic            isStore_q;
    logic [1:0]      size_q;
    logic            unsigned_q;
    logic [1:0]      offset_q;
    logic [CntW-1:0] cnt_q;
    logic            memReq_q;
    logic            memWe_q;
    logic [31:0]     memAddr_q;
    logic [3:0]      memBe_q;
    logic [31:0]     memWdata_q;
    logic            done_q;
    logic            err_q;
    logic [31:0]     rdata_q;

    logic            illegal_d;
    logic [3:0]      memBe_d;
    logic [31:0]     memWdata_d;
    logic [31:0]     shifted_d;
    logic [31:0]     loadExt_d;

    // Decode the incoming request: legality, byte enables and the store data
    // replicated onto every lane the access could touch.
    always_comb begin
        illegal_d  = 1'b0;
        memBe_d    = 4'b1111;
        memWdata_d = wdata_i;

        if (funct3_i[1:0] == 2'd3) begin
            illegal_d = 1'b1;
        end
        if ((funct3_i[1:0] == 2'd1) && addr_i[0]) begin
            illegal_d = 1'b1;
        end
        if ((funct3_i[1:0] == 2'd2) && (addr_i[1:0] != 2'd0)) begin
            illegal_d = 1'b1;
        end
        if (is_store_i && funct3_i[2]) begin
            illegal_d = 1'b1;
        end
        // funct3=6 would be an RV64 lwu, which has no meaning on RV32I.
        if (!is_store_i && (funct3_i == 3'b110)) begin
            illegal_d = 1'b1;
        end

        case (funct3_i[1:0])
            2'd0: begin
                memBe_d    = 4'b0001 << addr_i[1:0];
                memWdata_d = {4{wdata_i[7:0]}};
            end
            2'd1: begin
                memBe_d    = 4'b0011 << addr_i[1:0];
                memWdata_d = {2{wdata_i[15:0]}};
            end
            default: begin
                memBe_d    = 4'b1111;
                memWdata_d = wdata_i;
            end
        endcase
    end

    // Align the returned word so the addressed byte sits in lane 0, then
    // extend according to the latched size and signedness.
    always_comb begin
        shifted_d = mem_rdata_i >> {offset_q, 3'b000};
        loadExt_d = shifted_d;
        case (size_q)
            2'd0: loadExt_d = unsigned_q ? {24'd0, shifted_d[7:0]}
                                         : {{24{shifted_d[7]}}, shifted_d[7:0]};
            2'd1: loadExt_d = unsigned_q ? {16'd0, shifted_d[15:0]}
                                         : {{16{shifted_d[15]}}, shifted_d[15:0]};
            default: loadExt_d = shifted_d;
        endcase
    end

    // Sequencer. Every output except stall is a register so the memory and
    // the core see glitch-free signals. The timeout counter only advances
    // while a request or a response is outstanding and saturates at its last
    // value, where the access is abandoned unless it completes that cycle.
    // A load granted in the final counted cycle is still abandoned, because
    // its data could only arrive after the time budget has run out.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            isStore_q  <= 1'b0;
            size_q     <= 2'd0;
            unsigned_q <= 1'b0;
            offset_q   <= 2'd0;
            cnt_q      <= '0;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= 32'd0;
            memBe_q    <= 4'd0;
            memWdata_q <= 32'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        isStore_q  <= is_store_i;
                        size_q     <= funct3_i[1:0];
                        unsigned_q <= funct3_i[2];
                        offset_q   <= addr_i[1:0];
                        memWe_q    <= is_store_i;
                        memAddr_q  <= {addr_i[31:2], 2'b00};
                        memBe_q    <= memBe_d;
                        memWdata_q <= memWdata_d;
                        if (illegal_d) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= 32'd0;
                        end else begin
                            state_q  <= REQ;
                            memReq_q <= 1'b1;
                            cnt_q    <= '0;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt_i && isStore_q) begin
                        state_q  <= DONE;
                        memReq_q <= 1'b0;
                        done_q   <= 1'b1;
                        rdata_q  <= 32'd0;
                    end else if (cnt_q == CntLast) begin
                        state_q  <= DONE;
                        memReq_q <= 1'b0;
                        done_q   <= 1'b1;
                        err_q    <= 1'b1;
                        rdata_q  <= 32'd0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (mem_gnt_i) begin
                            state_q  <= WAIT;
                            memReq_q <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        rdata_q <= loadExt_d;
                    end else if (cnt_q == CntLast) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= 32'd0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Stall is combinational so the core freezes in the very cycle it
    // presents an access. It drops in DONE so the core advances on the edge
    // that ends the access, and it is held low while reset is asserted.
    assign stall_o = rst_ni & (((state_q == IDLE) & valid_i) |
                               (state_q == REQ) | (state_q == WAIT));

    assign done_o      = done_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign mem_req_o   = memReq_q;
    assign mem_we_o    = memWe_q;
    assign mem_addr_o  = memAddr_q;
    assign mem_be_o    = memBe_q;
    assign mem_wdata_o = memWdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl
//
// Self-checking bench for lsu_ctrl. Directed accesses first, then a run of
// random loads and stores. Expected values come from a behavioural model of
// the load/store rules (byte lists and plain arithmetic) and from the
// documented latency rules.
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rstN;
    logic        valid;
    logic        isStore;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [3:0]  memBe;
    logic [31:0] memWdata;
    logic        memGnt;
    logic        memRvalid;
    logic [31:0] memRdata;

    int          nVectors = 0;
    int          nMiscompares = 0;
    logic [31:0] expRdata = 32'd0;

    lsu_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .valid_i      (valid),
        .is_store_i   (isStore),
        .funct3_i     (funct3),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .stall_o      (stall),
        .done_o       (done),
        .err_o        (err),
        .rdata_o      (rdata),
        .mem_req_o    (memReq),
        .mem_we_o     (memWe),
        .mem_addr_o   (memAddr),
        .mem_be_o     (memBe),
        .mem_wdata_o  (memWdata),
        .mem_gnt_i    (memGnt),
        .mem_rvalid_i (memRvalid),
        .mem_rdata_i  (memRdata)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Hard stop in case the design never returns to idle.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    // ---------------- behavioural model ----------------

    function automatic bit modelIllegal(input bit st, input logic [2:0] f3, input logic [31:0] a);
        int nb;
        int off;
        if (f3[1:0] == 2'd3) return 1'b1;
        nb  = 1 << f3[1:0];
        off = int'(a[1:0]);
        if ((off % nb) != 0) return 1'b1;
        if (st && f3[2]) return 1'b1;
        if (!st && (f3 == 3'd6)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] modelBe(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] be;
        int nb;
        int off;
        nb  = 1 << f3[1:0];
        off = int'(a[1:0]);
        for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + nb);
        return be;
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] w;
        int nb;
        nb = 1 << f3[1:0];
        for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % nb) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
        longint v;
        longint lim;
        int nb;
        int off;
        nb  = 1 << f3[1:0];
        off = int'(a[1:0]);
        v   = 0;
        for (int k = 0; k < nb; k++) begin
            v += longint'((word >> (8 * (off + k))) & 32'hFF) << (8 * k);
        end
        lim = longint'(1) << (8 * nb - 1);
        if (!f3[2] && (v >= lim)) v -= 2 * lim;
        return v[31:0];
    endfunction

    // ---------------- helpers ----------------

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nVectors++;
        assert (observed === expected) else begin
            nMiscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        nVectors++;
        assert (observed === expected) else begin
            nMiscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Present one access in the current (idle) cycle and follow it to its
    // completion. gntDelay/rvDelay place the grant and the response relative
    // to the first request cycle and the grant. Returns one cycle after done,
    // with valid still asserted so the caller may chain accesses.
    task automatic applyStimulus(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rword,
                                 input int gntDelay, input int rvDelay, input bit earlyRvalid);
        bit          ill;
        bit          toErr;
        int          g;
        int          r;
        int          doneAt;
        int          reqEnd;
        logic [31:0] expResult;

        ill   = modelIllegal(st, f3, a);
        toErr = 1'b0;
        g     = 1 + gntDelay;
        r     = g + rvDelay;
        if (ill) begin
            doneAt = 1;
            reqEnd = 0;
        end else begin
            reqEnd = (g < TIMEOUT) ? g : TIMEOUT;
            if (st) begin
                if (g > TIMEOUT) begin
                    toErr  = 1'b1;
                    doneAt = TIMEOUT + 1;
                end else begin
                    doneAt = g + 1;
                end
            end else begin
                if (r > TIMEOUT) begin
                    toErr  = 1'b1;
                    doneAt = TIMEOUT + 1;
                end else begin
                    doneAt = r + 1;
                end
            end
        end
        expResult = (ill || toErr || st) ? 32'd0 : modelLoad(f3, a, rword);

        valid     = 1'b1;
        isStore   = st;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        memGnt    = 1'b0;
        memRvalid = 1'b0;
        memRdata  = 32'd0;
        #1;
        checkBit("stall_c0", stall, 1'b1);

        for (int c = 1; c <= doneAt; c++) begin
            nextCycle();
            memGnt    = 1'b0;
            memRvalid = 1'b0;
            memRdata  = 32'd0;
            checkBit("done", done, c == doneAt);
            checkBit("stall", stall, c < doneAt);
            checkBit("mem_req", memReq, c <= reqEnd);
            if (c <= reqEnd) begin
                checkBit("mem_we", memWe, st);
                checkOutput("mem_addr", memAddr, {a[31:2], 2'b00});
                checkOutput("mem_be", {28'd0, memBe}, {28'd0, modelBe(f3, a)});
                if (st) checkOutput("mem_wdata", memWdata, modelWdata(f3, wd));
            end
            if (c == doneAt) begin
                checkBit("err", err, ill || toErr);
                checkOutput("rdata", rdata, expResult);
            end
            if ((c == g) && (c <= reqEnd)) memGnt = 1'b1;
            if (!st && !ill && (c == r) && (r <= TIMEOUT)) begin
                memRvalid = 1'b1;
                memRdata  = rword;
            end else if (earlyRvalid && !st && !ill && (c == g) && (c <= reqEnd)) begin
                memRvalid = 1'b1;
                memRdata  = ~rword;
            end
        end

        expRdata = expResult;
        nextCycle();
        checkBit("done_after", done, 1'b0);
        checkBit("mem_req_after", memReq, 1'b0);
        checkOutput("rdata_hold", rdata, expRdata);
    endtask

    // ---------------- directed and random sequence ----------------

    initial begin
        bit          st;
        logic [2:0]  f3;
        logic [31:0] a;
        int          gd;

        rstN      = 1'b0;
        valid     = 1'b1;
        isStore   = 1'b1;
        funct3    = 3'b010;
        addr      = 32'h0000_0040;
        wdata     = 32'h1234_5678;
        memGnt    = 1'b0;
        memRvalid = 1'b0;
        memRdata  = 32'd0;

        nextCycle();
        nextCycle();
        checkBit("rst_stall", stall, 1'b0);
        checkBit("rst_mem_req", memReq, 1'b0);
        checkBit("rst_mem_we", memWe, 1'b0);
        checkBit("rst_done", done, 1'b0);
        checkBit("rst_err", err, 1'b0);
        checkOutput("rst_mem_addr", memAddr, 32'd0);
        checkOutput("rst_mem_wdata", memWdata, 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        checkOutput("rst_mem_be", {28'd0, memBe}, 32'd0);
        valid = 1'b0;
        rstN  = 1'b1;
        nextCycle();

        $display("[TB] directed accesses");
        applyStimulus(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'd0, 0, 1, 1'b0);
        applyStimulus(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'd0, 1, 1, 1'b0);
        applyStimulus(1'b0, 3'b000, 32'h0000_0102, 32'd0, 32'h0080_7F00, 0, 3, 1'b0);
        checkOutput("lb_value", rdata, 32'hFFFF_FF80);
        applyStimulus(1'b0, 3'b100, 32'h0000_0102, 32'd0, 32'h0080_7F00, 0, 3, 1'b1);
        checkOutput("lbu_value", rdata, 32'h0000_0080);

        $display("[TB] reset during WAIT");
        valid   = 1'b1;
        isStore = 1'b0;
        funct3  = 3'b010;
        addr    = 32'h0000_0300;
        nextCycle();
        memGnt = 1'b1;
        nextCycle();
        memGnt = 1'b0;
        checkBit("wait_mem_req", memReq, 1'b0);
        checkBit("wait_stall", stall, 1'b1);
        rstN = 1'b0;
        #1;
        checkBit("rst_forces_stall", stall, 1'b0);
        nextCycle();
        rstN  = 1'b1;
        valid = 1'b0;
        #1;
        checkBit("midrst_mem_req", memReq, 1'b0);
        checkBit("midrst_done", done, 1'b0);
        checkBit("midrst_stall", stall, 1'b0);
        checkOutput("midrst_rdata", rdata, 32'd0);
        checkOutput("midrst_mem_addr", memAddr, 32'd0);
        memRvalid = 1'b1;
        memRdata  = 32'hCAFE_F00D;
        nextCycle();
        memRvalid = 1'b0;
        checkBit("midrst_no_done", done, 1'b0);
        checkOutput("midrst_rdata_kept", rdata, 32'd0);
        expRdata = 32'd0;
        applyStimulus(1'b1, 3'b010, 32'h0000_0400, 32'h0BAD_CAFE, 32'd0, 2, 1, 1'b0);

        $display("[TB] illegal access and timeout");
        valid = 1'b0;
        nextCycle();
        applyStimulus(1'b0, 3'b001, 32'h0000_0101, 32'd0, 32'd0, 0, 1, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'h0000_0200, 32'd0, 32'h1111_2222, 100, 1, 1'b0);
        valid     = 1'b0;
        memRvalid = 1'b1;
        memRdata  = 32'h1234_5678;
        nextCycle();
        memRvalid = 1'b0;
        checkBit("stray_done", done, 1'b0);
        checkBit("stray_mem_req", memReq, 1'b0);
        checkBit("stray_stall", stall, 1'b0);
        checkOutput("stray_rdata", rdata, 32'd0);

        $display("[TB] random accesses");
        for (int n = 0; n < 60; n++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'd1) a[0] = 1'b0;
                if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
            end
            gd = ($urandom_range(0, 15) == 0) ? 20 : int'($urandom_range(0, 4));
            applyStimulus(st, f3, a, $urandom, $urandom, gd, int'($urandom_range(1, 4)),
                          1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                valid = 1'b0;
                nextCycle();
            end
        end
        valid = 1'b0;
        nextCycle();

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
